sa_load_controller: RTL and testbench

Sequencing controller directly upstream of the systolic array. It accepts eight 16-lane rows of 16-bit operands over a valid/ready stream and writes them into the array's register file (IDX 0..7), holding the write phase long enough for the array's input pipeline to drain. It then deasserts WRITE for a fixed matmul window and pulses DONE. It replaces hand-driven EN/RF_EN/WRITE/IDX/DIN sequencing.

---
 rtl/sa_load_controller_if.sv | 40 ++++
 rtl/sa_load_controller.sv | 139 +++++++++++++
 tb/tb_sa_load_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sa_load_controller_if.sv
// Purpose : bundles the row stream, job control and systolic-array drive signals.
// Latency : none (pure wiring).
// Backpressure: row_ready is driven by the controller; the row stream holds data until accepted.
// Signals:
//   start                          job request, from the host
//   row_valid/row_ready/row_data   row stream, lane k = row_data[DATA_W*k +: DATA_W]
//   busy/done                      job status, to the host
//   sa_en/sa_rf_en/sa_write        array control
//   sa_idx/sa_din                  array register-file index and lane data (sa_din[k] = SA_DIN_k)
interface sa_load_controller_if #(
  parameter int ROWS   = 8,
  parameter int LANES  = 16,
  parameter int DATA_W = 16
);
  localparam int IDX_W = $clog2(ROWS);

  logic                              start;
  logic                              row_valid;
  logic                              row_ready;
  logic [LANES*DATA_W-1:0]           row_data;
  logic                              busy;
  logic                              done;
  logic                              sa_en;
  logic                              sa_rf_en;
  logic                              sa_write;
  logic [IDX_W-1:0]                  sa_idx;
  logic [LANES-1:0][DATA_W-1:0]      sa_din;

  // Controller side.
  modport slave (
    input  start, row_valid, row_data,
    output row_ready, busy, done, sa_en, sa_rf_en, sa_write, sa_idx, sa_din
  );

  // Host / stimulus side.
  modport master (
    output start, row_valid, row_data,
    input  row_ready, busy, done, sa_en, sa_rf_en, sa_write, sa_idx, sa_din
  );
endinterface

// File: rtl/sa_load_controller.sv
// Purpose : sequences ROWS streamed rows into the systolic-array register file, flushes, then runs a matmul window.
// Latency : an accepted row reaches sa_idx/sa_din one cycle after its handshake; job = ROWS+FLUSH+COMPUTE+2 cycles.
// Backpressure: row_ready is high for the whole LOAD phase; row_valid gaps stall the job without losing rows.
// Ports:
//   clk_i, rst_n_i   clock (rising edge) and asynchronous active-low reset
//   bus (slave)      start / row stream in; busy, done and array drive signals out (all registered)
module sa_load_controller #(
  parameter int ROWS           = 8,
  parameter int LANES          = 16,
  parameter int DATA_W         = 16,
  parameter int FLUSH_CYCLES   = 3,
  parameter int COMPUTE_CYCLES = 30
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  sa_load_controller_if.slave    bus
);

  localparam int IDX_W   = $clog2(ROWS);
  localparam int PH_MAX  = (FLUSH_CYCLES > COMPUTE_CYCLES) ? FLUSH_CYCLES : COMPUTE_CYCLES;
  localparam int PH_W    = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_COMPUTE,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             row_cnt_q, row_cnt_d;
  logic [PH_W-1:0]              ph_cnt_q, ph_cnt_d;
  logic                         row_ready_q, row_ready_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         sa_en_q, sa_en_d;
  logic                         sa_rf_en_q, sa_rf_en_d;
  logic                         sa_write_q, sa_write_d;
  logic [IDX_W-1:0]             sa_idx_q, sa_idx_d;
  logic [LANES-1:0][DATA_W-1:0] sa_din_q, sa_din_d;
  logic                         row_hs;

  // row_ready_q is only ever high in LOAD, so this is also the LOAD-state accept.
  assign row_hs = bus.row_valid & row_ready_q;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    sa_idx_d  = sa_idx_q;
    sa_din_d  = sa_din_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (row_hs) begin
          sa_idx_d  = row_cnt_q;
          sa_din_d  = bus.row_data;
          row_cnt_d = row_cnt_q + IDX_W'(1);
          if (row_cnt_q == IDX_W'(ROWS - 1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (ph_cnt_q == PH_W'(FLUSH_CYCLES - 1)) state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (ph_cnt_q == PH_W'(COMPUTE_CYCLES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Phase counter restarts from zero on every state entry and only runs in the timed phases.
    if ((state_d != state_q) || !((state_q == S_FLUSH) || (state_q == S_COMPUTE))) begin
      ph_cnt_d = '0;
    end else begin
      ph_cnt_d = ph_cnt_q + PH_W'(1);
    end

    // Returning to IDLE clears the array-facing data so the next job starts from a known state.
    if (state_d == S_IDLE) begin
      row_cnt_d = '0;
      sa_idx_d  = '0;
      sa_din_d  = '0;
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state.
    row_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    sa_en_d     = (state_d != S_IDLE);
    sa_rf_en_d  = (state_d != S_IDLE);
    sa_write_d  = (state_d == S_LOAD) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      ph_cnt_q    <= '0;
      row_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sa_en_q     <= 1'b0;
      sa_rf_en_q  <= 1'b0;
      sa_write_q  <= 1'b0;
      sa_idx_q    <= '0;
      sa_din_q    <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      ph_cnt_q    <= ph_cnt_d;
      row_ready_q <= row_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sa_en_q     <= sa_en_d;
      sa_rf_en_q  <= sa_rf_en_d;
      sa_write_q  <= sa_write_d;
      sa_idx_q    <= sa_idx_d;
      sa_din_q    <= sa_din_d;
    end
  end

  assign bus.row_ready = row_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sa_en     = sa_en_q;
  assign bus.sa_rf_en  = sa_rf_en_q;
  assign bus.sa_write  = sa_write_q;
  assign bus.sa_idx    = sa_idx_q;
  assign bus.sa_din    = sa_din_q;

endmodule

// File: tb/tb_sa_load_controller.sv
module tb_sa_load_controller;

  localparam int ROWS   = 8;
  localparam int LANES  = 16;
  localparam int DATA_W = 16;

  logic clk_i;
  logic rst_n_i;
  int   tests;
  int   fails;

  sa_load_controller_if #(.ROWS(ROWS), .LANES(LANES), .DATA_W(DATA_W)) bus ();

  sa_load_controller #(
    .ROWS(ROWS), .LANES(LANES), .DATA_W(DATA_W),
    .FLUSH_CYCLES(3), .COMPUTE_CYCLES(30)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LANES*DATA_W-1:0] make_row(input int mode, input int r);
    logic [LANES*DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mode == 1) v[DATA_W*k +: DATA_W] = 16'h0100 + 16'(r * 16) + 16'(k);
      else           v[DATA_W*k +: DATA_W] = 16'(r + 1);
    end
    return v;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] junk(input int t);
    logic [LANES*DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) v[DATA_W*k +: DATA_W] = 16'hD000 + 16'(t * 16) + 16'(k);
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},  bus.row_ready, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_done"},   bus.done, 0);
    chk({tag, "_en"},     bus.sa_en, 0);
    chk({tag, "_rf_en"},  bus.sa_rf_en, 0);
    chk({tag, "_write"},  bus.sa_write, 0);
    chk({tag, "_idx"},    32'(bus.sa_idx), 0);
    for (int k = 0; k < LANES; k++) chk($sformatf("%s_din%0d", tag, k), 32'(bus.sa_din[k]), 0);
  endtask

  // Runs one job starting in the current (IDLE) cycle = relative cycle 0.
  // gap_len bubble cycles follow the acceptance of row gap_after.
  task automatic run_job(input string tag, input int mode, input int gap_after, input int gap_len,
                         input bit extra_starts, input int abort_at);
    int r;
    int B;
    bit ld;
    bit fl;
    logic [2:0]               e_idx, n_idx;
    logic [LANES*DATA_W-1:0]  e_din, n_din;
    B = gap_len;
    r = 0;
    n_idx = '0;
    n_din = '0;
    bus.start     = 1'b1;
    bus.row_valid = 1'b1;
    bus.row_data  = junk(0);
    for (int t = 1; t <= 43 + B; t++) begin
      tick();
      e_idx = n_idx;
      e_din = n_din;
      if (t == 43 + B) begin
        e_idx = '0;
        e_din = '0;
      end
      ld = (t >= 1) && (t <= 8 + B);
      fl = (t >= 9 + B) && (t <= 11 + B);
      chk($sformatf("%s_c%0d_ready", tag, t), bus.row_ready, ld);
      chk($sformatf("%s_c%0d_busy", tag, t), bus.busy, t != 43 + B);
      chk($sformatf("%s_c%0d_done", tag, t), bus.done, t == 42 + B);
      chk($sformatf("%s_c%0d_en", tag, t), bus.sa_en, t != 43 + B);
      chk($sformatf("%s_c%0d_rf_en", tag, t), bus.sa_rf_en, t != 43 + B);
      chk($sformatf("%s_c%0d_write", tag, t), bus.sa_write, ld || fl);
      chk($sformatf("%s_c%0d_idx", tag, t), 32'(bus.sa_idx), 32'(e_idx));
      for (int k = 0; k < LANES; k++)
        chk($sformatf("%s_c%0d_din%0d", tag, t, k), 32'(bus.sa_din[k]), 32'(e_din[DATA_W*k +: DATA_W]));
      if (t == abort_at) return;
      // Drive inputs for cycle t.
      bus.start = extra_starts && ((t == 5) || (t == 20) || (t == 42));
      if (ld) begin
        bus.row_valid = !((t >= gap_after + 2) && (t < gap_after + 2 + B));
        if (bus.row_valid) begin
          bus.row_data = make_row(mode, r);
          n_idx = r[2:0];
          n_din = make_row(mode, r);
          r++;
        end else begin
          bus.row_data = junk(t);
        end
      end else begin
        // Valid rows outside LOAD must be ignored.
        bus.row_valid = (t % 2) == 0;
        bus.row_data  = junk(t);
      end
    end
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n_i       = 1'b1;
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = '0;

    // Reset asserted mid-cycle with inputs active; outputs must clear before any clock edge.
    #2;
    bus.start     = 1'b1;
    bus.row_valid = 1'b1;
    bus.row_data  = junk(1);
    rst_n_i = 1'b0;
    #1;
    chk_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.start    = ~bus.start;
      bus.row_data = junk(i + 2);
      chk_zero("rst_hold");
    end
    bus.start     = 1'b0;
    bus.row_valid = 1'b0;
    #2;
    rst_n_i = 1'b1;
    tick();
    chk_zero("post_rst");
    tick();
    chk_zero("idle_nostart");

    // Back-to-back load, ignored STARTs at 5/20/42, then a new job started at cycle 43.
    run_job("b2b", 0, -1, 0, 1'b1, -1);
    // Lane mapping job, started in the IDLE cycle immediately after the previous DONE.
    run_job("lane", 1, -1, 0, 1'b0, -1);
    tick();
    chk_zero("idle_after_lane");

    // Three-cycle bubble after row 3: DONE moves to cycle 45.
    run_job("gap", 0, 3, 3, 1'b0, -1);
    tick();

    // Reset during COMPUTE at cycle 25, held for 2 cycles.
    run_job("abort", 0, -1, 0, 1'b0, 25);
    bus.start = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_zero("abort_async");
    tick();
    chk_zero("abort_hold1");
    tick();
    chk_zero("abort_hold2");
    #2;
    rst_n_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_zero($sformatf("abort_idle%0d", i));
    end

    // Full job after the aborted one.
    run_job("rerun", 1, -1, 0, 1'b0, -1);
    tick();
    chk_zero("final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
